reg_bank: RTL and testbench

Parametrised multi-entry register bank generalising the single N-bit chip-enabled register: DEPTH entries of WIDTH bits, one byte-enabled write port, two registered read ports, a synchronous bulk clear and per-entry dirty tracking. It sits beside the control/status logic as the shared configuration and scratch store. The single-register block stays for one-off flops.

---
 rtl/reg_bank_pkg.sv | 22 ++
 rtl/reg_bank_if.sv | 33 +++
 rtl/reg_bank_rdport.sv | 49 ++++
 rtl/reg_bank.sv | 80 ++++++++
 tb/tb_reg_bank.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and the byte-merge helper for reg_bank.
package reg_bank_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAX_W  = 1024;
  localparam int unsigned MAX_NB = MAX_W / BYTE_W;

  // Callers zero-extend their WIDTH-sized operands to MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0]  old_data,
    input logic [MAX_W-1:0]  new_data,
    input logic [MAX_NB-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old_data;
    for (int unsigned i = 0; i < MAX_NB; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Write, read and status bus of reg_bank.
interface reg_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  import reg_bank_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / BYTE_W;

  logic             CE;
  logic             CLR;
  logic             WE;
  logic [AW-1:0]    WADDR;
  logic [NB-1:0]    WBE;
  logic [WIDTH-1:0] WDATA;
  logic [AW-1:0]    RADDR0;
  logic [AW-1:0]    RADDR1;
  logic [WIDTH-1:0] RDATA0;
  logic [WIDTH-1:0] RDATA1;
  logic [DEPTH-1:0] DIRTY;

  modport master (
    output CE, CLR, WE, WADDR, WBE, WDATA, RADDR0, RADDR1,
    input  RDATA0, RDATA1, DIRTY
  );

  modport slave (
    input  CE, CLR, WE, WADDR, WBE, WDATA, RADDR0, RADDR1,
    output RDATA0, RDATA1, DIRTY
  );

endinterface

// File: rtl/reg_bank_rdport.sv
// One registered read port of reg_bank; same-edge forwarding of writes/clears
// is built only when REG_BANK_BYPASS_EN is defined.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      DEPTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         ce,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  entries,
  output logic [WIDTH-1:0]             rdata
`ifdef REG_BANK_BYPASS_EN
  , input logic                        clr
  , input logic                        wr_hit
  , input logic [$clog2(DEPTH)-1:0]    waddr
  , input logic [WIDTH/BYTE_W-1:0]     wbe
  , input logic [WIDTH-1:0]            wdata
`endif
);

  logic [WIDTH-1:0] load;

  always_comb begin
    load = INITIAL_VALUE;
    if (32'(raddr) < DEPTH) begin
      load = entries[raddr];
`ifdef REG_BANK_BYPASS_EN
      if (clr) begin
        load = INITIAL_VALUE;
      end else if (wr_hit && (waddr == raddr)) begin
        load = WIDTH'(merge_bytes(MAX_W'(entries[raddr]), MAX_W'(wdata), MAX_NB'(wbe)));
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rdata <= INITIAL_VALUE;
    end else if (ce) begin
      rdata <= load;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Multi-entry byte-enabled register bank with two registered read ports,
// bulk clear and per-entry dirty bits. Define REG_BANK_BYPASS_EN for read bypass.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      DEPTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input logic        CLK,
  input logic        RSTN,
  reg_bank_if.slave  bus
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            dirty;
  logic                        wr_hit;

  // An empty byte mask is treated as no write so it cannot mark the entry dirty.
  assign wr_hit = bus.WE && (32'(bus.WADDR) < DEPTH) && (bus.WBE != '0);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      mem   <= {DEPTH{INITIAL_VALUE}};
      dirty <= '0;
    end else if (bus.CE) begin
      if (bus.CLR) begin
        mem   <= {DEPTH{INITIAL_VALUE}};
        dirty <= '0;
      end else if (wr_hit) begin
        mem[bus.WADDR]   <= WIDTH'(merge_bytes(MAX_W'(mem[bus.WADDR]), MAX_W'(bus.WDATA),
                                               MAX_NB'(bus.WBE)));
        dirty[bus.WADDR] <= 1'b1;
      end
    end
  end

  assign bus.DIRTY = dirty;

  reg_bank_rdport #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_rd0 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .ce      (bus.CE),
    .raddr   (bus.RADDR0),
    .entries (mem),
    .rdata   (bus.RDATA0)
`ifdef REG_BANK_BYPASS_EN
    , .clr    (bus.CLR)
    , .wr_hit (wr_hit)
    , .waddr  (bus.WADDR)
    , .wbe    (bus.WBE)
    , .wdata  (bus.WDATA)
`endif
  );

  reg_bank_rdport #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_rd1 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .ce      (bus.CE),
    .raddr   (bus.RADDR1),
    .entries (mem),
    .rdata   (bus.RDATA1)
`ifdef REG_BANK_BYPASS_EN
    , .clr    (bus.CLR)
    , .wr_hit (wr_hit)
    , .waddr  (bus.WADDR)
    , .wbe    (bus.WBE)
    , .wdata  (bus.WDATA)
`endif
  );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: a DEPTH=4 and a DEPTH=3 instance share stimulus.
module tb_reg_bank;

  localparam logic [15:0] INIT = 16'hA5A5;
`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rstn;

  reg_bank_if #(.WIDTH(16), .DEPTH(4)) bus4 ();
  reg_bank_if #(.WIDTH(16), .DEPTH(3)) bus3 ();

  reg_bank #(.WIDTH(16), .DEPTH(4), .INITIAL_VALUE(INIT)) dut4 (
    .CLK (clk), .RSTN (rstn), .bus (bus4)
  );
  reg_bank #(.WIDTH(16), .DEPTH(3), .INITIAL_VALUE(INIT)) dut3 (
    .CLK (clk), .RSTN (rstn), .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a0, a1;
    logic [3:0]  da;
    logic [15:0] b0, b1;
    logic [2:0]  db;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: index 0 models DEPTH=4, index 1 models DEPTH=3.
  logic [15:0] mm [2][4];
  logic [3:0]  md [2];
  logic [15:0] mr [2][2];

  task automatic model_step(input int k, input logic r, c, cl, w,
                            input logic [1:0] wa, be, input logic [15:0] wd,
                            input logic [1:0] a0, a1);
    int          depth;
    logic [15:0] nxt [4];
    logic [15:0] mask;
    logic [1:0]  addr;
    depth = (k == 0) ? 4 : 3;
    if (!r) begin
      for (int e = 0; e < 4; e++) mm[k][e] = INIT;
      md[k] = '0;
      mr[k][0] = INIT;
      mr[k][1] = INIT;
    end else if (c) begin
      for (int e = 0; e < 4; e++) nxt[e] = mm[k][e];
      if (cl) begin
        for (int e = 0; e < 4; e++) nxt[e] = INIT;
        md[k] = '0;
      end else if (w && int'(wa) < depth && be != 2'b00) begin
        mask    = {{8{be[1]}}, {8{be[0]}}};
        nxt[wa] = (nxt[wa] & ~mask) | (wd & mask);
        md[k][wa] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        addr = (p == 0) ? a0 : a1;
        if (int'(addr) >= depth) mr[k][p] = INIT;
        else                     mr[k][p] = BYP ? nxt[addr] : mm[k][addr];
      end
      for (int e = 0; e < 4; e++) mm[k][e] = nxt[e];
    end
  endtask

  task automatic cyc(input logic r, c, cl, w, input logic [1:0] wa, be,
                     input logic [15:0] wd, input logic [1:0] a0, a1);
    exp_t e;
    rstn = r;
    bus4.CE = c;  bus4.CLR = cl; bus4.WE = w;  bus4.WADDR = wa;
    bus4.WBE = be; bus4.WDATA = wd; bus4.RADDR0 = a0; bus4.RADDR1 = a1;
    bus3.CE = c;  bus3.CLR = cl; bus3.WE = w;  bus3.WADDR = wa;
    bus3.WBE = be; bus3.WDATA = wd; bus3.RADDR0 = a0; bus3.RADDR1 = a1;
    model_step(0, r, c, cl, w, wa, be, wd, a0, a1);
    model_step(1, r, c, cl, w, wa, be, wd, a0, a1);
    e.a0 = mr[0][0]; e.a1 = mr[0][1]; e.da = md[0];
    e.b0 = mr[1][0]; e.b1 = mr[1][1]; e.db = md[1][2:0];
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata0_d4", bus4.RDATA0, e.a0);
        chk("rdata1_d4", bus4.RDATA1, e.a1);
        chk("dirty_d4", 16'(bus4.DIRTY), 16'(e.da));
        chk("rdata0_d3", bus3.RDATA0, e.b0);
        chk("rdata1_d3", bus3.RDATA1, e.b1);
        chk("dirty_d3", 16'(bus3.DIRTY), 16'(e.db));
      end
    end
  end

  initial begin
    // Reset with random write/clear traffic.
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
          16'($urandom), 2'($urandom), 2'($urandom));
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd0, 2'd1);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd2, 2'd3);
    // Low-byte write, then read back.
    cyc(1, 1, 0, 1, 2'd2, 2'b01, 16'h1234, 2'd2, 2'd0);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd2, 2'd2);
    // Read of the entry being written on the same edge.
    cyc(1, 1, 0, 1, 2'd1, 2'b11, 16'hBEEF, 2'd0, 2'd1);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd1, 2'd1);
    // Clear collides with a write.
    cyc(1, 1, 1, 1, 2'd0, 2'b11, 16'h0F0F, 2'd2, 2'd1);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd0, 2'd1);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd2, 2'd3);
    // Entry 3 is out of range for the DEPTH=3 instance.
    cyc(1, 1, 0, 1, 2'd3, 2'b11, 16'h1111, 2'd3, 2'd3);
    // CE low holds everything.
    cyc(1, 0, 0, 1, 2'd3, 2'b11, 16'h5555, 2'd1, 2'd0);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd3, 2'd3);
    // WBE=0 writes nothing.
    cyc(1, 1, 0, 1, 2'd0, 2'b00, 16'hFFFF, 2'd0, 2'd0);
    cyc(1, 1, 0, 0, 2'd0, 2'b00, 16'h0, 2'd0, 2'd3);
    for (int i = 0; i < 600; i++)
      cyc(1'(($urandom % 50) != 0), 1'(($urandom % 8) != 0), 1'(($urandom % 25) == 0),
          1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 2'($urandom));
    for (int i = 0; i < 5; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
